// File: rtl/aes_ark_if.sv
// Handshake and data bundle between the cipher controller, the round
// datapath and the AddRoundKey engine.
interface aes_ark_if;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [127:0] text_in;
    logic [127:0] sa_next;
    logic [127:0] rk;
    logic [127:0] state;
    logic         out_valid;
    logic [3:0]   rnd;
    logic         last_rnd;

    // Requester side: issues operations and consumes the state.
    modport master (
        output in_valid, op, text_in, sa_next, rk,
        input  in_ready, state, out_valid, rnd, last_rnd
    );

    // Engine side.
    modport slave (
        input  in_valid, op, text_in, sa_next, rk,
        output in_ready, state, out_valid, rnd, last_rnd
    );
endinterface

// File: rtl/aes_ark_engine.sv
// AddRoundKey engine: holds the 128-bit AES state and XORs one round key
// per operation into either fresh plaintext (load) or the round-datapath
// output (round), LANES bytes per cycle. Byte 0 (sa00) is the MSB byte.
module aes_ark_engine #(
    parameter int LANES = 16,
    parameter int NR    = 10
) (
    input  logic     clk,
    input  logic     rst,
    aes_ark_if.slave bus
);
    localparam int              BEATS     = 16 / LANES;
    localparam int              BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
    localparam logic [3:0]      NR_RND    = 4'(NR);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XOR  = 1'b1
    } fsm_t;

    fsm_t          fsm_r;
    logic          op_r;
    logic [127:0]  src_r;
    logic [127:0]  rk_r;
    logic [127:0]  state_r;
    logic [BW-1:0] beat_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [3:0]    rnd_r;

    logic          accept_s;
    logic [127:0]  state_nxt_s;
    logic [3:0]    rnd_nxt_s;

    // One AddRoundKey byte lane: plain bitwise XOR, no carries.
    function automatic logic [7:0] ark_byte(input logic [7:0] src_byte,
                                            input logic [7:0] key_byte);
        return src_byte ^ key_byte;
    endfunction

    // MSB bit position of byte idx (byte 0 lives at [127:120]).
    function automatic int byte_msb(input int idx);
        return 127 - 8 * (idx % 16);
    endfunction

    // in_ready_r is high exactly while idle, so this is the accept strobe.
    assign accept_s = bus.in_valid & in_ready_r;

    // Next round index on completion: load restarts at 0, round counts up to 15.
    always_comb begin
        rnd_nxt_s = 4'd0;
        if (op_r) begin
            if (rnd_r == 4'd15) begin
                rnd_nxt_s = 4'd15;
            end else begin
                rnd_nxt_s = rnd_r + 4'd1;
            end
        end else begin
            rnd_nxt_s = 4'd0;
        end
    end

    // State with the current beat's LANES bytes replaced by src ^ rk.
    always_comb begin
        state_nxt_s = state_r;
        for (int l = 0; l < LANES; l++) begin
            state_nxt_s[byte_msb(int'(beat_r) * LANES + l) -: 8] =
                ark_byte(src_r[byte_msb(int'(beat_r) * LANES + l) -: 8],
                         rk_r[byte_msb(int'(beat_r) * LANES + l) -: 8]);
        end
    end

    // Control FSM with working registers, state register and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r       <= ST_IDLE;
            op_r        <= 1'b0;
            src_r       <= 128'h0;
            rk_r        <= 128'h0;
            state_r     <= 128'h0;
            beat_r      <= {BW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            rnd_r       <= 4'd0;
        end else begin
            out_valid_r <= 1'b0;
            case (fsm_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // Inputs may change after accept, so capture everything.
                        op_r       <= bus.op;
                        src_r      <= bus.op ? bus.sa_next : bus.text_in;
                        rk_r       <= bus.rk;
                        beat_r     <= {BW{1'b0}};
                        in_ready_r <= 1'b0;
                        fsm_r      <= ST_XOR;
                    end
                end
                ST_XOR: begin
                    state_r <= state_nxt_s;
                    if (beat_r == LAST_BEAT) begin
                        beat_r      <= {BW{1'b0}};
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                        rnd_r       <= rnd_nxt_s;
                        fsm_r       <= ST_IDLE;
                    end else begin
                        beat_r <= beat_r + BW'(1);
                    end
                end
                default: begin
                    fsm_r      <= ST_IDLE;
                    beat_r     <= {BW{1'b0}};
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.state     = state_r;
    assign bus.out_valid = out_valid_r;
    assign bus.rnd       = rnd_r;
    assign bus.last_rnd  = (rnd_r == NR_RND);

endmodule

// File: tb/tb_aes_ark_engine.sv
// Directed bench for aes_ark_engine across several LANES/NR configurations.
module tb_aes_ark_engine;
    localparam logic [127:0] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_RK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] ONES    = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] B_SA    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_RK    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_RES   = 128'h00102030405060708090a0b0c0d0e0f0;

    logic clk;
    logic rst;
    logic rst_b;
    int   checks;
    int   errors;

    aes_ark_if if16();
    aes_ark_if if4();
    aes_ark_if if1();
    aes_ark_if if2();
    aes_ark_if if14();

    aes_ark_engine #(.LANES(16), .NR(10)) u16 (.clk(clk), .rst(rst),   .bus(if16));
    aes_ark_engine #(.LANES(4),  .NR(10)) u4  (.clk(clk), .rst(rst),   .bus(if4));
    aes_ark_engine #(.LANES(1),  .NR(10)) u1  (.clk(clk), .rst(rst),   .bus(if1));
    aes_ark_engine #(.LANES(2),  .NR(10)) u2  (.clk(clk), .rst(rst_b), .bus(if2));
    aes_ark_engine #(.LANES(16), .NR(14)) u14 (.clk(clk), .rst(rst),   .bus(if14));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if16.state !== 128'h0) begin errors++; $display("FAIL reset_state got %h exp 0", if16.state); end
        checks++; if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", if16.out_valid); end
        checks++; if (if16.rnd !== 4'd0) begin errors++; $display("FAIL reset_rnd got %0d exp 0", if16.rnd); end
        checks++; if (if16.last_rnd !== 1'b0) begin errors++; $display("FAIL reset_last_rnd got %b exp 0", if16.last_rnd); end
        checks++; if (if14.last_rnd !== 1'b0) begin errors++; $display("FAIL reset_last_rnd_nr14 got %b exp 0", if14.last_rnd); end
        checks++; if (if4.state !== 128'h0) begin errors++; $display("FAIL reset_state_l4 got %h exp 0", if4.state); end
        rst = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        checks++; if (if16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", if16.in_ready); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_l2 got %b exp 1", if2.in_ready); end
    endtask

    task automatic test_fips16();
        if16.op = 1'b0; if16.text_in = FIPS_PT; if16.rk = FIPS_RK; if16.sa_next = 128'h0;
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0; if16.text_in = 128'h0; if16.rk = 128'h0;
        checks++; if (if16.in_ready !== 1'b0) begin errors++; $display("FAIL fips16_busy got %b exp 0", if16.in_ready); end
        @(posedge clk); #1;
        checks++; if (if16.out_valid !== 1'b1) begin errors++; $display("FAIL fips16_out_valid got %b exp 1", if16.out_valid); end
        checks++; if (if16.state !== FIPS_CT) begin errors++; $display("FAIL fips16_state got %h exp %h", if16.state, FIPS_CT); end
        checks++; if (if16.rnd !== 4'd0) begin errors++; $display("FAIL fips16_rnd got %0d exp 0", if16.rnd); end
        checks++; if (if16.in_ready !== 1'b1) begin errors++; $display("FAIL fips16_ready got %b exp 1", if16.in_ready); end
        @(posedge clk); #1;
        checks++; if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL fips16_pulse got %b exp 0", if16.out_valid); end
        checks++; if (if16.state !== FIPS_CT) begin errors++; $display("FAIL fips16_hold got %h exp %h", if16.state, FIPS_CT); end
    endtask

    task automatic test_lanes4();
        int ov_cnt;
        ov_cnt = 0;
        if4.op = 1'b0; if4.text_in = FIPS_PT; if4.rk = FIPS_RK; if4.sa_next = 128'h0;
        if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0; if4.text_in = 128'h0; if4.rk = 128'h0;
        checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL l4_busy got %b exp 0", if4.in_ready); end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (if4.out_valid === 1'b1) ov_cnt++;
            if (k == 1) begin
                checks++; if (if4.state !== {32'h193de3be, 96'h0}) begin errors++; $display("FAIL l4_beat0 got %h exp %h", if4.state, {32'h193de3be, 96'h0}); end
            end
            if (k < 4) begin
                checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL l4_ready_low k=%0d got %b exp 0", k, if4.in_ready); end
            end
            if (k == 4) begin
                checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL l4_out_valid got %b exp 1", if4.out_valid); end
                checks++; if (if4.state !== FIPS_CT) begin errors++; $display("FAIL l4_state got %h exp %h", if4.state, FIPS_CT); end
            end
        end
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL l4_pulses got %0d exp 1", ov_cnt); end
    endtask

    task automatic test_round_chain();
        logic [127:0] exp_state;
        exp_state = 128'h0;
        for (int i = 0; i <= 10; i++) begin
            if (i == 0) begin
                if16.op = 1'b0; if16.text_in = FIPS_PT; if16.rk = FIPS_RK;
                exp_state = FIPS_CT;
            end else begin
                if16.op = 1'b1; if16.sa_next = exp_state; if16.rk = ONES;
                exp_state = exp_state ^ ONES;
            end
            if16.in_valid = 1'b1;
            @(posedge clk); #1;
            if16.in_valid = 1'b0;
            checks++; if (if16.in_ready !== 1'b0) begin errors++; $display("FAIL chain_accept op=%0d got %b exp 0", i, if16.in_ready); end
            @(posedge clk); #1;
            checks++; if (if16.out_valid !== 1'b1) begin errors++; $display("FAIL chain_valid op=%0d got %b exp 1", i, if16.out_valid); end
            checks++; if (if16.state !== exp_state) begin errors++; $display("FAIL chain_state op=%0d got %h exp %h", i, if16.state, exp_state); end
            checks++; if (if16.rnd !== 4'(i)) begin errors++; $display("FAIL chain_rnd op=%0d got %0d exp %0d", i, if16.rnd, i); end
            checks++; if (if16.last_rnd !== (i == 10)) begin errors++; $display("FAIL chain_last op=%0d got %b exp %b", i, if16.last_rnd, (i == 10)); end
        end
        @(posedge clk); #1;
        checks++; if (if16.out_valid !== 1'b0) begin errors++; $display("FAIL chain_end got %b exp 0", if16.out_valid); end
    endtask

    task automatic test_back_to_back_busy();
        int extra_acc;
        int ov_cnt;
        extra_acc = 0; ov_cnt = 0;
        if1.op = 1'b0; if1.text_in = FIPS_PT; if1.rk = FIPS_RK; if1.sa_next = 128'h0;
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (if1.in_ready !== 1'b0) begin errors++; $display("FAIL busy_accept_a got %b exp 0", if1.in_ready); end
        if1.op = 1'b1; if1.sa_next = B_SA; if1.rk = B_RK; if1.text_in = ONES;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (if1.out_valid === 1'b1) ov_cnt++;
            if (k < 16 && if1.in_ready !== 1'b0) extra_acc++;
            if (k == 16) begin
                checks++; if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL busy_a_valid got %b exp 1", if1.out_valid); end
                checks++; if (if1.state !== FIPS_CT) begin errors++; $display("FAIL busy_a_state got %h exp %h", if1.state, FIPS_CT); end
                checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL busy_a_ready got %b exp 1", if1.in_ready); end
            end
        end
        checks++; if (extra_acc !== 0) begin errors++; $display("FAIL busy_extra_accepts got %0d exp 0", extra_acc); end
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL busy_a_pulses got %0d exp 1", ov_cnt); end
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        checks++; if (if1.in_ready !== 1'b0) begin errors++; $display("FAIL busy_accept_b got %b exp 0", if1.in_ready); end
        ov_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k < 16 && if1.out_valid !== 1'b0) ov_cnt++;
            if (k == 16) begin
                checks++; if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL busy_b_valid got %b exp 1", if1.out_valid); end
                checks++; if (if1.state !== B_RES) begin errors++; $display("FAIL busy_b_state got %h exp %h", if1.state, B_RES); end
                checks++; if (if1.rnd !== 4'd1) begin errors++; $display("FAIL busy_b_rnd got %0d exp 1", if1.rnd); end
            end
        end
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL busy_b_early got %0d exp 0", ov_cnt); end
    endtask

    task automatic test_reset_mid_op();
        int ov_cnt;
        ov_cnt = 0;
        if2.op = 1'b0; if2.text_in = FIPS_PT; if2.rk = FIPS_RK; if2.sa_next = 128'h0;
        if2.in_valid = 1'b1;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (if2.out_valid !== 1'b0) ov_cnt++;
        end
        checks++; if (if2.state !== {48'h193de3bea0f4, 80'h0}) begin errors++; $display("FAIL rstmid_partial got %h exp %h", if2.state, {48'h193de3bea0f4, 80'h0}); end
        rst_b = 1'b1;
        if2.op = 1'b1; if2.sa_next = ONES; if2.rk = ONES; if2.in_valid = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0; if2.in_valid = 1'b0;
        checks++; if (if2.state !== 128'h0) begin errors++; $display("FAIL rstmid_state got %h exp 0", if2.state); end
        checks++; if (if2.rnd !== 4'd0) begin errors++; $display("FAIL rstmid_rnd got %0d exp 0", if2.rnd); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", if2.in_ready); end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (if2.out_valid !== 1'b0) ov_cnt++;
        end
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", ov_cnt); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %b exp 1", if2.in_ready); end
        if2.op = 1'b0; if2.text_in = FIPS_PT; if2.rk = FIPS_RK; if2.in_valid = 1'b1;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k < 8 && if2.out_valid !== 1'b0) ov_cnt++;
            if (k == 8) begin
                checks++; if (if2.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_redo_valid got %b exp 1", if2.out_valid); end
                checks++; if (if2.state !== FIPS_CT) begin errors++; $display("FAIL rstmid_redo_state got %h exp %h", if2.state, FIPS_CT); end
            end
        end
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL rstmid_redo_early got %0d exp 0", ov_cnt); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_rnd;
        if14.op = 1'b1; if14.sa_next = 128'h0; if14.rk = B_RK; if14.text_in = 128'h0;
        for (int i = 1; i <= 17; i++) begin
            exp_rnd = (i > 15) ? 4'd15 : 4'(i);
            if14.in_valid = 1'b1;
            @(posedge clk); #1;
            if14.in_valid = 1'b0;
            @(posedge clk); #1;
            checks++; if (if14.out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid op=%0d got %b exp 1", i, if14.out_valid); end
            checks++; if (if14.rnd !== exp_rnd) begin errors++; $display("FAIL sat_rnd op=%0d got %0d exp %0d", i, if14.rnd, exp_rnd); end
            checks++; if (if14.last_rnd !== (exp_rnd == 4'd14)) begin errors++; $display("FAIL sat_last op=%0d got %b exp %b", i, if14.last_rnd, (exp_rnd == 4'd14)); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; rst_b = 1'b1;
        if16.in_valid = 1'b0; if16.op = 1'b0; if16.text_in = 128'h0; if16.sa_next = 128'h0; if16.rk = 128'h0;
        if4.in_valid  = 1'b0; if4.op  = 1'b0; if4.text_in  = 128'h0; if4.sa_next  = 128'h0; if4.rk  = 128'h0;
        if1.in_valid  = 1'b0; if1.op  = 1'b0; if1.text_in  = 128'h0; if1.sa_next  = 128'h0; if1.rk  = 128'h0;
        if2.in_valid  = 1'b0; if2.op  = 1'b0; if2.text_in  = 128'h0; if2.sa_next  = 128'h0; if2.rk  = 128'h0;
        if14.in_valid = 1'b0; if14.op = 1'b0; if14.text_in = 128'h0; if14.sa_next = 128'h0; if14.rk = 128'h0;
        test_reset();
        test_fips16();
        test_lanes4();
        test_round_chain();
        test_back_to_back_busy();
        test_reset_mid_op();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
